// File: rtl/seg_display_scheduler_if.sv
// Bundle between telemetry requesters, the display driver and the scheduler.
// The scheduler sits on the slave side; the requester/driver side is the master.
interface seg_display_scheduler_if #(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = 3
);
  logic [NUM_SRC-1:0]    src_valid;
  logic [16*NUM_SRC-1:0] src_data;
  logic [NUM_SRC-1:0]    src_ack;
  logic                  hold;
  logic [15:0]           disp_bcd;
  logic [SRC_W-1:0]      disp_src;
  logic                  disp_valid;
  logic                  disp_ovf;
  logic                  busy;

  modport master (
    output src_valid, src_data, hold,
    input  src_ack, disp_bcd, disp_src, disp_valid, disp_ovf, busy
  );

  modport slave (
    input  src_valid, src_data, hold,
    output src_ack, disp_bcd, disp_src, disp_valid, disp_ovf, busy
  );
endinterface

// File: rtl/seg_display_scheduler.sv
// Round-robin display arbiter: captures one requester value, converts it to BCD
// with a serial double-dabble engine, publishes it and holds it for a dwell time.
module seg_display_scheduler #(
  parameter int NUM_SRC      = 4,
  parameter int DWELL_CYCLES = 100000000,
  parameter int SRC_W        = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  seg_display_scheduler_if.slave bus
);

  localparam int DW_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_CYCLES - 1);
  localparam logic [15:0]     BCD_MAX    = 16'd9999;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_CONVERT = 3'd2,
    ST_PUBLISH = 3'd3,
    ST_DWELL   = 3'd4
  } state_t;

  state_t               state_r;
  logic [1:0]           rst_sync_r;
  logic [SRC_W-1:0]     rr_r;
  logic [SRC_W-1:0]     winner_r;
  logic [15:0]          bcd_r;
  logic [15:0]          sr_r;
  logic [3:0]           step_r;
  logic                 ovf_pend_r;
  logic [DW_W-1:0]      dwell_r;
  logic [NUM_SRC-1:0]   ack_r;
  logic [15:0]          disp_bcd_r;
  logic [SRC_W-1:0]     disp_src_r;
  logic                 disp_valid_r;
  logic                 disp_ovf_r;
  logic                 busy_r;

  logic [SRC_W:0]       pick_s;
  logic [15:0]          captured_s;
  logic [15:0]          adj_s;

  // First valid requester strictly after rr, wrapping; MSB flags that one exists.
  function automatic logic [SRC_W:0] pick_next(input logic [NUM_SRC-1:0] valid,
                                               input logic [SRC_W-1:0]   rr);
    logic             found;
    logic [SRC_W-1:0] idx;
    int               cand;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      cand = int'(rr) + i;
      if (cand >= NUM_SRC) begin
        cand = cand - NUM_SRC;
      end else begin
        cand = cand;
      end
      if (!found && valid[cand]) begin
        found = 1'b1;
        idx   = SRC_W'(cand);
      end else begin
        found = found;
      end
    end
    return {found, idx};
  endfunction

  // Double-dabble correction: every BCD nibble of 5 or more gets 3 added before the shift.
  function automatic logic [15:0] dabble_adjust(input logic [15:0] bcd);
    logic [15:0] res;
    res = bcd;
    for (int n = 0; n < 4; n++) begin
      if (res[4*n +: 4] >= 4'd5) begin
        res[4*n +: 4] = res[4*n +: 4] + 4'd3;
      end else begin
        res[4*n +: 4] = res[4*n +: 4];
      end
    end
    return res;
  endfunction

  // Arbitration candidate, winner data mux and BCD nibble correction.
  always_comb begin
    pick_s     = pick_next(bus.src_valid, rr_r);
    adj_s      = dabble_adjust(bcd_r);
    captured_s = 16'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (winner_r == SRC_W'(i)) begin
        captured_s = bus.src_data[16*i +: 16];
      end else begin
        captured_s = captured_s;
      end
    end
  end

  // Reset release synchroniser; assertion is immediate, release takes two edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  // Scheduler FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      rr_r         <= SRC_W'(NUM_SRC - 1);
      winner_r     <= '0;
      bcd_r        <= 16'd0;
      sr_r         <= 16'd0;
      step_r       <= 4'd0;
      ovf_pend_r   <= 1'b0;
      dwell_r      <= '0;
      ack_r        <= '0;
      disp_bcd_r   <= 16'd0;
      disp_src_r   <= '0;
      disp_valid_r <= 1'b0;
      disp_ovf_r   <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      ack_r <= '0;
      case (state_r)
        ST_IDLE: begin
          // Nothing starts until the reset release has propagated through the synchroniser.
          if (rst_sync_r[1] && !bus.hold && pick_s[SRC_W]) begin
            winner_r <= pick_s[SRC_W-1:0];
            busy_r   <= 1'b1;
            state_r  <= ST_CAPTURE;
          end else begin
            state_r  <= ST_IDLE;
          end
        end
        ST_CAPTURE: begin
          if (captured_s > BCD_MAX) begin
            sr_r       <= BCD_MAX;
            ovf_pend_r <= 1'b1;
          end else begin
            sr_r       <= captured_s;
            ovf_pend_r <= 1'b0;
          end
          bcd_r   <= 16'd0;
          step_r  <= 4'd0;
          ack_r   <= NUM_SRC'(1'b1) << winner_r;
          rr_r    <= winner_r;
          state_r <= ST_CONVERT;
        end
        ST_CONVERT: begin
          bcd_r  <= {adj_s[14:0], sr_r[15]};
          sr_r   <= {sr_r[14:0], 1'b0};
          step_r <= step_r + 4'd1;
          if (step_r == 4'd15) begin
            state_r <= ST_PUBLISH;
          end else begin
            state_r <= ST_CONVERT;
          end
        end
        ST_PUBLISH: begin
          disp_bcd_r   <= bcd_r;
          disp_src_r   <= winner_r;
          disp_ovf_r   <= ovf_pend_r;
          disp_valid_r <= 1'b1;
          dwell_r      <= '0;
          busy_r       <= 1'b0;
          state_r      <= ST_DWELL;
        end
        ST_DWELL: begin
          if (bus.hold) begin
            dwell_r <= dwell_r;
          end else if (dwell_r == DWELL_LAST) begin
            state_r <= ST_IDLE;
          end else begin
            dwell_r <= dwell_r + DW_W'(1);
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.src_ack    = ack_r;
  assign bus.disp_bcd   = disp_bcd_r;
  assign bus.disp_src   = disp_src_r;
  assign bus.disp_valid = disp_valid_r;
  assign bus.disp_ovf   = disp_ovf_r;
  assign bus.busy       = busy_r;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Randomised scoreboard bench for seg_display_scheduler: stimulus pushes the
// expected publication on each ack, a monitor pops it when the DUT publishes.
module tb_seg_display_scheduler;
  localparam int NUM_SRC = 4;
  localparam int SRC_W   = 3;
  localparam int DWELL   = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_display_scheduler_if #(.NUM_SRC(NUM_SRC), .SRC_W(SRC_W)) bus ();

  seg_display_scheduler #(.NUM_SRC(NUM_SRC), .DWELL_CYCLES(DWELL), .SRC_W(SRC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [15:0]      bcd;
    logic [SRC_W-1:0] src;
    logic             ovf;
    int               ack_cyc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   held_total = 0;
  int   held_at_pub = 0;
  int   last_pub = -1;
  int   model_rr = NUM_SRC - 1;
  logic [15:0] last_bcd = 16'd0;
  int   vals[NUM_SRC];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h) at cycle %0d",
               name, act, act, req, req, cyc);
    end
  endtask

  function automatic logic [15:0] ref_bcd(input int v);
    int s;
    s = (v > 9999) ? 9999 : v;
    return 16'(((s / 1000) << 12) | (((s / 100) % 10) << 8) | (((s / 10) % 10) << 4) | (s % 10));
  endfunction

  function automatic int ref_pick(input logic [NUM_SRC-1:0] v, input int rr);
    for (int k = 1; k <= NUM_SRC; k++) begin
      if (v[(rr + k) % NUM_SRC]) return (rr + k) % NUM_SRC;
    end
    return -1;
  endfunction

  task automatic set_val(input int i, input int v);
    vals[i] = v;
    bus.src_data[16*i +: 16] = 16'(v);
  endtask

  always @(posedge clk) begin
    cyc++;
    if (bus.hold) held_total++;
  end

  // Monitor: a falling busy marks a publication; otherwise the display must not move.
  logic        prev_busy = 1'b0;
  logic [15:0] prev_bcd = 16'd0;
  logic [SRC_W-1:0] prev_src = '0;
  logic        prev_valid = 1'b0;
  logic        prev_ovf = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_busy = 1'b0; prev_bcd = 16'd0; prev_src = '0; prev_valid = 1'b0; prev_ovf = 1'b0;
    end else begin
      if (prev_busy && !bus.busy) begin
        if (sbq.size() == 0) begin
          check("unexpected_publish", 1, 0);
        end else begin
          e = sbq.pop_front();
          check("disp_bcd", int'(bus.disp_bcd), int'(e.bcd));
          check("disp_src", int'(bus.disp_src), int'(e.src));
          check("disp_ovf", int'(bus.disp_ovf), int'(e.ovf));
          check("disp_valid", int'(bus.disp_valid), 1);
          check("latency", cyc - e.ack_cyc, 17);
          last_bcd = e.bcd;
        end
        last_pub = cyc;
        held_at_pub = held_total;
      end else begin
        check("display_stable", int'({bus.disp_bcd, bus.disp_src, bus.disp_valid, bus.disp_ovf}),
              int'({prev_bcd, prev_src, prev_valid, prev_ovf}));
      end
      prev_busy = bus.busy; prev_bcd = bus.disp_bcd; prev_src = bus.disp_src;
      prev_valid = bus.disp_valid; prev_ovf = bus.disp_ovf;
    end
  end

  task automatic wait_ack(output bit got);
    got = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (|bus.src_ack) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("ack_timeout", 0, 1);
  endtask

  task automatic wait_publish();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!bus.busy) return;
    end
    check("publish_timeout", 0, 1);
  endtask

  // Checks an observed ack against round-robin order and queues the expected display.
  task automatic step(input bit check_gap);
    bit   got;
    int   idx;
    exp_t e;
    wait_ack(got);
    if (got) begin
      idx = -1;
      for (int i = 0; i < NUM_SRC; i++) if (bus.src_ack[i]) idx = i;
      check("ack_onehot", $countones(bus.src_ack), 1);
      check("ack_src", idx, ref_pick(bus.src_valid, model_rr));
      if (check_gap && last_pub >= 0)
        check("dwell_gap", cyc - last_pub, DWELL + 2 + (held_total - held_at_pub));
      if (idx >= 0) begin
        e.bcd = ref_bcd(vals[idx]);
        e.src = SRC_W'(idx);
        e.ovf = (vals[idx] > 9999);
        e.ack_cyc = cyc;
        sbq.push_back(e);
        model_rr = idx;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bcd"}, int'(bus.disp_bcd), 0);
    check({tag, "_src"}, int'(bus.disp_src), 0);
    check({tag, "_valid"}, int'(bus.disp_valid), 0);
    check({tag, "_ovf"}, int'(bus.disp_ovf), 0);
    check({tag, "_ack"}, int'(bus.src_ack), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
  endtask

  initial begin
    int acks;
    bus.src_valid = '0;
    bus.hold = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) set_val(i, 0);
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");

    set_val(0, 1234);
    bus.src_valid = 4'b0001;
    rst_n = 1'b1;
    step(1'b0);

    set_val(0, 5); set_val(1, 42); set_val(2, 7777); set_val(3, 9999);
    bus.src_valid = 4'b1011;
    step(1'b1); step(1'b1); step(1'b1);

    set_val(2, 65535);
    bus.src_valid = 4'b0100;
    step(1'b1);
    set_val(3, 0);
    bus.src_valid = 4'b1000;
    step(1'b1);

    repeat (16) begin
      bus.src_valid = NUM_SRC'($urandom_range(1, (1 << NUM_SRC) - 1));
      for (int i = 0; i < NUM_SRC; i++)
        set_val(i, ($urandom_range(0, 3) == 0) ? int'($urandom_range(10000, 65535))
                                               : int'($urandom_range(0, 9999)));
      step(1'b1);
    end

    // Freeze in dwell for 50 cycles.
    wait_publish();
    repeat (3) @(posedge clk);
    #1 bus.hold = 1'b1;
    repeat (50) @(posedge clk);
    #1 bus.hold = 1'b0;
    step(1'b1);

    // Hold raised during conversion: the sequence completes, then freezes.
    bus.hold = 1'b1;
    repeat (30) @(posedge clk);
    #1 bus.hold = 1'b0;
    step(1'b1);

    // Reset in the middle of a conversion.
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    sbq.delete();
    model_rr = NUM_SRC - 1;
    last_pub = -1;
    bus.src_valid = 4'b1111;
    for (int i = 0; i < NUM_SRC; i++) set_val(i, int'($urandom_range(0, 9999)));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step(1'b0);

    // No requesters: the last value stays up and nothing is acknowledged.
    bus.src_valid = '0;
    wait_publish();
    acks = 0;
    repeat (60) begin
      @(negedge clk);
      if (|bus.src_ack) acks++;
    end
    check("idle_acks", acks, 0);
    check("idle_valid", int'(bus.disp_valid), 1);
    check("idle_bcd", int'(bus.disp_bcd), int'(last_bcd));
    check("scoreboard_empty", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seg_display_scheduler.md
Name: seg_display_scheduler

Overview:
- Shares the 4-digit seven-segment display between up to NUM_SRC telemetry requesters on the rover (speed, distance, sensor readings, status code).
- Round-robin schedules which requester is shown and holds each selection for a fixed dwell time.
- Converts the selected 16-bit binary value to four BCD digits with a sequential double-dabble engine; no divide or modulo logic.
- Feeds the digit-multiplex driver, which only scans the 16-bit BCD word it is given.

Parameters:
- NUM_SRC, 4, number of requesters (2..8).
- DWELL_CYCLES, 100000000, clk cycles each selection stays displayed (1 s at 100 MHz); benches use 8.
- SRC_W, 3, width of source index; must satisfy 2**SRC_W >= NUM_SRC.

Ports:
- clk  in  1  100 MHz system clock.
- rst_n  in  1  asynchronous active-low reset.
- src_valid  in  NUM_SRC  bit i high means requester i has a value to show; level, not pulse.
- src_data  in  16*NUM_SRC  requester i value in bits [16i+15:16i], unsigned binary.
- src_ack  out  NUM_SRC  one-cycle pulse on the bit of the requester whose value was captured.
- hold  in  1  freezes rotation on the current selection.
- disp_bcd  out  16  four BCD digits; [15:12] is thousands, [3:0] is units.
- disp_src  out  SRC_W  index of the requester currently displayed.
- disp_valid  out  1  high once at least one value has been published.
- disp_ovf  out  1  high when the displayed value was saturated.
- busy  out  1  high in CAPTURE, CONVERT and PUBLISH.

Behaviour:
- Reset (async assert, sync deassert internally):
  - disp_bcd=0, disp_src=0, disp_valid=0, disp_ovf=0, src_ack=0, busy=0.
  - State=IDLE; rr pointer=NUM_SRC-1, so source 0 has first priority.
- States: IDLE, CAPTURE, CONVERT, PUBLISH, DWELL.
- IDLE:
  - If hold=0 and any src_valid is high, pick the first valid index searching upward from rr+1 with wrap, then go to CAPTURE.
  - Otherwise stay in IDLE; outputs keep their last published value.
- CAPTURE (1 cycle):
  - Latch src_data of the winner and pulse its src_ack bit.
  - rr <= winner.
  - If the value > 9999, substitute 9999 and set the pending ovf flag.
- CONVERT (exactly 16 cycles):
  - Double dabble over a 16-bit BCD accumulator plus 16-bit shift register, MSB first.
  - Each cycle, add 3 to every BCD nibble >= 5, then shift left 1.
- PUBLISH (1 cycle): register disp_bcd, disp_src=winner, disp_ovf=pending flag, disp_valid=1.
- Latency: the CAPTURE cycle is edge N; new outputs are visible after edge N+17.
- DWELL:
  - Counter runs from 0 to DWELL_CYCLES-1, then returns to IDLE.
  - The counter does not advance while hold=1.
  - If the selected source drops src_valid during DWELL, the displayed value is kept until dwell ends.
- Single valid source: that source is re-captured every dwell period, so its value refreshes.
- src_valid changes during CAPTURE/CONVERT/PUBLISH: ignored; the latched value completes.
- hold asserted in CAPTURE/CONVERT/PUBLISH: the sequence completes, then the block freezes in DWELL.
- Reset mid-operation: immediate return to reset values. No src_ack is generated and no partial BCD value is published.
- src_data is sampled only in CAPTURE; requesters keep data stable while valid.

Test Plan:
- Reset, then src_valid=0001, src_data[15:0]=1234 → src_ack=0001 for 1 cycle; 17 cycles later disp_bcd=16'h1234, disp_src=0, disp_valid=1, disp_ovf=0.
- src_valid=1011, values 5/42/(unused)/9999, DWELL_CYCLES=8 → disp_src sequence 0,1,3,0 with disp_bcd 0005,0042,9999,0005; each selection held ≥8 cycles.
- Source 2 value 65535 → disp_bcd=16'h9999, disp_ovf=1; next source value 0 → disp_bcd=16'h0000, disp_ovf=0.
- hold=1 during DWELL for 50 cycles → disp_src and disp_bcd unchanged and no src_ack pulses; rotation resumes after the remaining dwell once hold=0.
- rst_n pulled low at cycle 8 of CONVERT → all outputs zero immediately; after release the first src_ack goes to source 0.
- All src_valid=0 after one publish → block stays in IDLE; disp_valid stays 1 and disp_bcd holds its last value.
